// File: rtl/dmem_arbiter.sv
// Two-requester (integer / FP) data-memory arbiter with round-robin tie-break.
// Fixed four-phase transaction: IDLE grant, ACCESS strobe, CAPTURE data, ACK pulse.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  output logic        i_stall,
  input  logic        f_req,
  input  logic        f_we,
  input  logic [31:0] f_addr,
  input  logic [31:0] f_wdata,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_err,
  output logic        f_stall,
  output logic        mem_enable,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t          state_q;
  logic            owner_q;
  logic            last_grant_q;
  logic            we_q;
  logic            mis_q;
  logic            mem_enable_q;
  logic            mem_write_q;
  logic            mem_read_q;
  logic [DW-1:0]   address_q;
  logic [DW-1:0]   write_data_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   f_rdata_q;
  logic            i_err_q;
  logic            f_err_q;
  logic            i_ack_q;
  logic            f_ack_q;

  logic            i_pend_d;
  logic            f_pend_d;
  logic            any_pend_d;
  logic            grant_fp_d;
  logic            gnt_we_d;
  logic [DW-1:0]   gnt_addr_d;
  logic [DW-1:0]   gnt_wdata_d;
  logic            gnt_mis_d;

  // Arbitration: a requester still seeing its ack is not re-granted
  always_comb begin
    i_pend_d    = i_req && !i_ack_q;
    f_pend_d    = f_req && !f_ack_q;
    any_pend_d  = i_pend_d || f_pend_d;
    grant_fp_d  = f_pend_d && (!i_pend_d || !last_grant_q);
    gnt_we_d    = grant_fp_d ? f_we    : i_we;
    gnt_addr_d  = grant_fp_d ? f_addr  : i_addr;
    gnt_wdata_d = grant_fp_d ? f_wdata : i_wdata;
    gnt_mis_d   = (gnt_addr_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mis_q        <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      i_rdata_q    <= '0;
      f_rdata_q    <= '0;
      i_err_q      <= 1'b0;
      f_err_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      f_ack_q      <= 1'b0;
    end else begin
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      i_ack_q      <= 1'b0;
      f_ack_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_pend_d) begin
            owner_q      <= grant_fp_d;
            last_grant_q <= grant_fp_d;
            we_q         <= gnt_we_d;
            mis_q        <= gnt_mis_d;
            // Strobes are registered here so they are visible during ACCESS
            if (!gnt_mis_d) begin
              mem_enable_q <= 1'b1;
              mem_write_q  <= gnt_we_d;
              mem_read_q   <= !gnt_we_d;
              address_q    <= gnt_addr_d;
              write_data_q <= gnt_wdata_d;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: state_q <= CAPTURE;
        CAPTURE: begin
          if (owner_q) begin
            f_err_q <= mis_q;
            f_ack_q <= 1'b1;
            if (!mis_q && !we_q) f_rdata_q <= mem_data_out;
          end else begin
            i_err_q <= mis_q;
            i_ack_q <= 1'b1;
            if (!mis_q && !we_q) i_rdata_q <= mem_data_out;
          end
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack      = i_ack_q;
  assign f_ack      = f_ack_q;
  assign i_rdata    = i_rdata_q;
  assign f_rdata    = f_rdata_q;
  assign i_err      = i_err_q;
  assign f_err      = f_err_q;
  assign i_stall    = i_req && !i_ack_q;
  assign f_stall    = f_req && !f_ack_q;
  assign mem_enable = mem_enable_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign address    = address_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and data values.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        i_ack, i_err, i_stall;
  logic [31:0] i_rdata;
  logic        f_req = 1'b0, f_we = 1'b0;
  logic [31:0] f_addr = '0, f_wdata = '0;
  logic        f_ack, f_err, f_stall;
  logic [31:0] f_rdata;
  logic        mem_enable, mem_write, mem_read;
  logic [31:0] address, write_data;
  logic [31:0] mem_data_out = '0;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err), .i_stall(i_stall),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err), .f_stall(f_stall),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_read(mem_read),
    .address(address), .write_data(write_data), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory device seen by the DUT: one-cycle read latency
  logic [31:0] dmem [logic [31:0]];
  function automatic logic [31:0] drd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'h0;
  endfunction
  always @(posedge clk) begin
    if (mem_enable && mem_write) dmem[address] = write_data;
    if (mem_enable && mem_read) mem_data_out <= drd(address);
  end

  // Reference model: one transaction record, outputs derived from cycle offsets
  logic [31:0] mmem [logic [31:0]];
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  bit          m_ok = 1'b0;
  bit          m_last;
  logic [31:0] m_rdata [2];
  bit          m_err [2];
  bit          t_v = 1'b0, t_fp, t_we;
  logic [31:0] t_addr, t_wdata;
  int          t_n;
  int          cyc = 0;

  always @(negedge clk) begin
    bit acc, al, e_en, e_ack_i, e_ack_f, idle_now, pi, pf, gfp;
    acc     = t_v && (cyc == t_n + 1);
    al      = (t_addr[1:0] == 2'b00);
    e_en    = acc && al;
    e_ack_i = t_v && (cyc == t_n + 3) && !t_fp;
    e_ack_f = t_v && (cyc == t_n + 3) && t_fp;
    if (m_ok) begin
      chk("mem_enable", 32'(mem_enable), 32'(e_en));
      chk("mem_write",  32'(mem_write),  32'(e_en && t_we));
      chk("mem_read",   32'(mem_read),   32'(e_en && !t_we));
      chk("address",    address,    e_en ? t_addr  : 32'h0);
      chk("write_data", write_data, e_en ? t_wdata : 32'h0);
      chk("i_ack",   32'(i_ack),   32'(e_ack_i));
      chk("f_ack",   32'(f_ack),   32'(e_ack_f));
      chk("i_stall", 32'(i_stall), 32'(i_req && !e_ack_i));
      chk("f_stall", 32'(f_stall), 32'(f_req && !e_ack_f));
      chk("i_rdata", i_rdata, m_rdata[0]);
      chk("f_rdata", f_rdata, m_rdata[1]);
      chk("i_err",   32'(i_err), 32'(m_err[0]));
      chk("f_err",   32'(f_err), 32'(m_err[1]));
    end
    if (rst) begin
      m_ok = 1'b1; t_v = 1'b0; m_last = 1'b1;
      m_rdata[0] = '0; m_rdata[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
    end else if (m_ok) begin
      idle_now = !t_v;
      if (t_v && cyc == t_n + 2) begin
        m_err[t_fp] = !al;
        if (al && !t_we) m_rdata[t_fp] = mrd(t_addr);
      end
      if (t_v && cyc == t_n + 3) t_v = 1'b0;
      pi = i_req && !e_ack_i;
      pf = f_req && !e_ack_f;
      if (idle_now && (pi || pf)) begin
        gfp     = pf && (!pi || !m_last);
        m_last  = gfp;
        t_v     = 1'b1;
        t_fp    = gfp;
        t_we    = gfp ? f_we : i_we;
        t_addr  = gfp ? f_addr : i_addr;
        t_wdata = gfp ? f_wdata : i_wdata;
        t_n     = cyc;
        if (t_we && t_addr[1:0] == 2'b00) mmem[t_addr] = t_wdata;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request held until its ack, then dropped; counts strobes and records stall
  task automatic run_one(input bit fp, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output int nmem,
                         output logic [3:0] sp);
    lat = -1; nmem = 0; sp = '0;
    if (fp) begin f_req = 1'b1; f_we = we; f_addr = a; f_wdata = wd; end
    else    begin i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd; end
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      nmem += int'(mem_enable);
      if (k < 4) sp[k[1:0]] = fp ? f_stall : i_stall;
      if (fp ? f_ack : i_ack) lat = k;
      tick();
    end
    i_req = 1'b0; f_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      nmem += int'(mem_enable);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nmem, ia0, ia1, fa0, fa1, nack;
    logic [3:0] sp;
    dmem[32'h10] = 32'hDEADBEEF; mmem[32'h10] = 32'hDEADBEEF;
    dmem[32'h14] = 32'h12345678; mmem[32'h14] = 32'h12345678;
    do_reset();
    @(negedge clk);
    chk("reset i_rdata", i_rdata, 32'h0);
    chk("reset f_ack", 32'(f_ack), 32'h0);
    chk("reset mem_enable", 32'(mem_enable), 32'h0);
    tick();

    // Int aligned load
    run_one(1'b0, 1'b0, 32'h10, 32'h0, lat, nmem, sp);
    chk("ld lat", 32'(lat), 32'd3);
    chk("ld nmem", 32'(nmem), 32'd1);
    chk("ld stall", 32'(sp), 32'h7);
    chk("ld i_rdata", i_rdata, 32'hDEADBEEF);
    chk("ld i_err", 32'(i_err), 32'h0);

    // FP store then FP load back
    run_one(1'b1, 1'b1, 32'h20, 32'h3F800000, lat, nmem, sp);
    chk("st lat", 32'(lat), 32'd3);
    chk("st nmem", 32'(nmem), 32'd1);
    chk("st f_rdata kept", f_rdata, 32'h0);
    run_one(1'b1, 1'b0, 32'h20, 32'h0, lat, nmem, sp);
    chk("fld f_rdata", f_rdata, 32'h3F800000);

    // Misaligned int load, then aligned int store
    run_one(1'b0, 1'b0, 32'h13, 32'h0, lat, nmem, sp);
    chk("mis lat", 32'(lat), 32'd3);
    chk("mis nmem", 32'(nmem), 32'd0);
    chk("mis i_err", 32'(i_err), 32'h1);
    chk("mis i_rdata", i_rdata, 32'hDEADBEEF);
    run_one(1'b0, 1'b1, 32'h14, 32'hA5A5A5A5, lat, nmem, sp);
    chk("ist i_err", 32'(i_err), 32'h0);
    chk("ist i_rdata", i_rdata, 32'hDEADBEEF);

    // Misaligned FP store must not touch memory
    run_one(1'b1, 1'b1, 32'h22, 32'h11111111, lat, nmem, sp);
    chk("mst nmem", 32'(nmem), 32'd0);
    chk("mst f_err", 32'(f_err), 32'h1);
    run_one(1'b1, 1'b0, 32'h20, 32'h0, lat, nmem, sp);
    chk("mst reload", f_rdata, 32'h3F800000);
    chk("mst f_err clr", 32'(f_err), 32'h0);

    // Simultaneous requests right after reset, both held
    do_reset();
    ia0 = -1; ia1 = -1; fa0 = -1; fa1 = -1;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h10;
    f_req = 1'b1; f_we = 1'b0; f_addr = 32'h20;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (i_ack) begin if (ia0 < 0) ia0 = k; else if (ia1 < 0) ia1 = k; end
      if (f_ack) begin if (fa0 < 0) fa0 = k; else if (fa1 < 0) fa1 = k; end
      tick();
    end
    i_req = 1'b0; f_req = 1'b0;
    chk("rr i_ack0", 32'(ia0), 32'd3);
    chk("rr f_ack0", 32'(fa0), 32'd7);
    chk("rr i_ack1", 32'(ia1), 32'd11);
    chk("rr f_ack1", 32'(fa1), 32'd15);
    repeat (4) tick();
    chk("rr i_rdata", i_rdata, 32'hDEADBEEF);

    // Reset during CAPTURE aborts the load
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h10;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    chk("abort i_rdata", i_rdata, 32'h0);
    chk("abort mem_enable", 32'(mem_enable), 32'h0);
    nack = int'(i_ack);
    tick();
    repeat (4) begin @(negedge clk); nack += int'(i_ack); tick(); end
    chk("abort no ack", 32'(nack), 32'd0);
    run_one(1'b0, 1'b0, 32'h10, 32'h0, lat, nmem, sp);
    chk("post-abort lat", 32'(lat), 32'd3);
    chk("post-abort rdata", i_rdata, 32'hDEADBEEF);

    // FP store whose request and address change after the grant
    f_req = 1'b1; f_we = 1'b1; f_addr = 32'h30; f_wdata = 32'hCAFEF00D;
    tick();
    f_req = 1'b0; f_addr = 32'h40; f_wdata = 32'h0; f_we = 1'b0;
    lat = -1;
    for (int k = 1; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      if (f_ack) lat = k;
      tick();
    end
    chk("drop lat", 32'(lat), 32'd3);
    repeat (2) tick();
    run_one(1'b1, 1'b0, 32'h30, 32'h0, lat, nmem, sp);
    chk("drop reload", f_rdata, 32'hCAFEF00D);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
